axis_video_rx_checker: RTL and testbench

- AXI4-Stream video sink: the receiving end of the team's video stream source (tdata/tvalid/tuser/tlast with SOF on tuser, EOL on tlast).
- Accepts beats, tracks pixel x/y position and re-emits each accepted pixel with its coordinates.
- Checks frame structure against WIDTH×HEIGHT, keeps sticky error flags and per-frame counters/checksum, and resynchronises after malformed lines or frames.
- Used in benches and on-chip as the consumer/monitor behind the stream source and filter blocks.

---
 rtl/axis_video_pkg.sv | 17 +
 rtl/axis_lfsr16.sv | 28 ++
 rtl/axis_video_rx_checker.sv | 225 ++++++++++++++++++++++
 tb/tb_axis_video_rx_checker.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_video_pkg.sv
// Shared video-stream types and defaults for the stream source and the rx checker.
package axis_video_pkg;

  localparam int VID_N      = 8;
  localparam int VID_WIDTH  = 10;
  localparam int VID_HEIGHT = 10;

  // Fibonacci taps 16,14,13,11 expressed as state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    WAIT_SOF   = 2'd0,
    ACTIVE     = 2'd1,
    RESYNC_EOL = 2'd2
  } statetype;

endpackage

// File: rtl/axis_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left with the feedback bit entering at bit 0.
module axis_lfsr16
  import axis_video_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        fb;

  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = en_i ? {lfsr_q[14:0], fb} : lfsr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/axis_video_rx_checker.sv
// AXI4-Stream video sink: tracks x/y, re-emits pixels with coordinates and
// checks frame structure, keeping sticky errors, frame counters and a checksum.
module axis_video_rx_checker
  import axis_video_pkg::*;
#(
  parameter int          N         = VID_N,
  parameter int          WIDTH     = VID_WIDTH,
  parameter int          HEIGHT    = VID_HEIGHT,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         XW        = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int         YW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          stall_en,
  input  logic [N-1:0]  s_axis_video_tdata,
  input  logic          s_axis_video_tvalid,
  input  logic          s_axis_video_tuser,
  input  logic          s_axis_video_tlast,
  output logic          s_axis_video_tready,
  output logic          pix_valid,
  output logic [N-1:0]  pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_done,
  output logic          frame_ok,
  output logic [31:0]   frame_checksum,
  output logic [15:0]   frames_good,
  output logic [15:0]   frames_bad,
  output logic          err_early_eol,
  output logic          err_late_eol,
  output logic          err_early_sof,
  output logic          err_no_sof
);

  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

  logic [15:0] lfsr_state;
  logic        acc;

  axis_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .en_i    (1'b1),
    .state_o (lfsr_state)
  );

  // An all-zero state (zero seed) would lock tready low; release it instead.
  assign s_axis_video_tready = stall_en ? (lfsr_state[0] | ~(|lfsr_state)) : 1'b1;
  assign acc = s_axis_video_tvalid & s_axis_video_tready;

  statetype      state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          ferr_q, ferr_d;
  logic [31:0]   sum_q, sum_d;
  logic          pv_q, pv_d;
  logic [N-1:0]  pd_q, pd_d;
  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;
  logic          done_q, done_d;
  logic          ok_q, ok_d;
  logic [31:0]   cks_q, cks_d;
  logic [15:0]   good_q, good_d;
  logic [15:0]   bad_q, bad_d;
  logic          eeol_q, eeol_d;
  logic          leol_q, leol_d;
  logic          esof_q, esof_d;
  logic          nsof_q, nsof_d;

  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [31:0]   run_sum;
  logic          run_err;
  logic          pixel;
  logic          line_end;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    ferr_d   = ferr_q;
    sum_d    = sum_q;
    pv_d     = 1'b0;
    pd_d     = pd_q;
    px_d     = px_q;
    py_d     = py_q;
    done_d   = 1'b0;
    ok_d     = ok_q;
    cks_d    = cks_q;
    good_d   = good_q;
    bad_d    = bad_q;
    eeol_d   = eeol_q;
    leol_d   = leol_q;
    esof_d   = esof_q;
    nsof_d   = nsof_q;
    cx       = x_q;
    cy       = y_q;
    run_sum  = sum_q;
    run_err  = ferr_q;
    pixel    = 1'b0;
    line_end = 1'b0;

    if (acc) begin
      // SOF wins over everything else on the beat and restarts at (0,0)
      if (s_axis_video_tuser) begin
        if (state_q != WAIT_SOF) begin
          esof_d = 1'b1;
          bad_d  = bad_q + 16'd1;
        end
        cx      = '0;
        cy      = '0;
        run_sum = '0;
        run_err = 1'b0;
        pixel   = 1'b1;
      end else begin
        case (state_q)
          WAIT_SOF:   nsof_d = 1'b1;
          ACTIVE:     pixel = 1'b1;
          RESYNC_EOL: line_end = s_axis_video_tlast;
          default:    state_d = WAIT_SOF;
        endcase
      end

      if (pixel) begin
        pv_d    = 1'b1;
        pd_d    = s_axis_video_tdata;
        px_d    = cx;
        py_d    = cy;
        run_sum = run_sum + 32'(s_axis_video_tdata);
        y_d     = cy;
        if (s_axis_video_tlast) begin
          if (cx != XMAX) begin
            eeol_d  = 1'b1;
            run_err = 1'b1;
          end
          line_end = 1'b1;
        end else if (cx == XMAX) begin
          leol_d  = 1'b1;
          run_err = 1'b1;
          state_d = RESYNC_EOL;
        end else begin
          x_d     = cx + 1'b1;
          state_d = ACTIVE;
        end
      end

      if (line_end) begin
        if (cy == YMAX) begin
          done_d  = 1'b1;
          ok_d    = ~run_err;
          cks_d   = run_sum;
          state_d = WAIT_SOF;
          if (run_err) bad_d  = bad_d + 16'd1;
          else         good_d = good_q + 16'd1;
        end else begin
          x_d     = '0;
          y_d     = cy + 1'b1;
          state_d = ACTIVE;
        end
      end

      sum_d  = run_sum;
      ferr_d = run_err;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= WAIT_SOF;
      x_q     <= '0;
      y_q     <= '0;
      ferr_q  <= 1'b0;
      sum_q   <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      cks_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      eeol_q  <= 1'b0;
      leol_q  <= 1'b0;
      esof_q  <= 1'b0;
      nsof_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ferr_q  <= ferr_d;
      sum_q   <= sum_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      px_q    <= px_d;
      py_q    <= py_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      cks_q   <= cks_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      eeol_q  <= eeol_d;
      leol_q  <= leol_d;
      esof_q  <= esof_d;
      nsof_q  <= nsof_d;
    end
  end

  assign pix_valid      = pv_q;
  assign pix_data       = pd_q;
  assign pix_x          = px_q;
  assign pix_y          = py_q;
  assign frame_done     = done_q;
  assign frame_ok       = ok_q;
  assign frame_checksum = cks_q;
  assign frames_good    = good_q;
  assign frames_bad     = bad_q;
  assign err_early_eol  = eeol_q;
  assign err_late_eol   = leol_q;
  assign err_early_sof  = esof_q;
  assign err_no_sof     = nsof_q;

endmodule

// File: tb/tb_axis_video_rx_checker.sv
// Directed bench for axis_video_rx_checker with a 10x10 frame geometry.
module tb_axis_video_rx_checker;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        stall_en = 1'b0;
  logic [7:0]  tdata = 8'd0;
  logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
  logic        tready;
  logic        pix_valid, frame_done, frame_ok;
  logic [7:0]  pix_data;
  logic [3:0]  pix_x, pix_y;
  logic [31:0] frame_checksum;
  logic [15:0] frames_good, frames_bad;
  logic        err_early_eol, err_late_eol, err_early_sof, err_no_sof;

  axis_video_rx_checker #(.N(8), .WIDTH(10), .HEIGHT(10), .LFSR_SEED(16'hACE1)) dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .stall_en            (stall_en),
    .s_axis_video_tdata  (tdata),
    .s_axis_video_tvalid (tvalid),
    .s_axis_video_tuser  (tuser),
    .s_axis_video_tlast  (tlast),
    .s_axis_video_tready (tready),
    .pix_valid           (pix_valid),
    .pix_data            (pix_data),
    .pix_x               (pix_x),
    .pix_y               (pix_y),
    .frame_done          (frame_done),
    .frame_ok            (frame_ok),
    .frame_checksum      (frame_checksum),
    .frames_good         (frames_good),
    .frames_bad          (frames_bad),
    .err_early_eol       (err_early_eol),
    .err_late_eol        (err_late_eol),
    .err_early_sof       (err_early_sof),
    .err_no_sof          (err_no_sof)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  int   q_x[$], q_y[$], q_c[$];
  int   q_d[$];
  int   cyc = 0;
  int   ndone = 0;
  int   done_cyc = 0;
  logic last_ok = 1'b0;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (pix_valid) begin
      q_x.push_back(int'(pix_x));
      q_y.push_back(int'(pix_y));
      q_d.push_back(int'(pix_data));
      q_c.push_back(cyc);
    end
    if (frame_done) begin
      ndone    <= ndone + 1;
      done_cyc <= cyc;
      last_ok  <= frame_ok;
    end
  end

  task automatic clear_mon();
    q_x.delete(); q_y.delete(); q_d.delete(); q_c.delete();
  endtask

  task automatic settle();
    repeat (3) @(negedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    clear_mon();
  endtask

  // Hold a beat until the sink takes it; tready only moves on the rising edge.
  task automatic send(input logic [7:0] d, input logic u, input logic l);
    int n;
    n = 0;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    while (!tready && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout: waited %0d cycles, required < 200", n);
    end
    @(negedge sys_clk);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 100; i++) send(8'(i), i == 0, (i % 10) == 9);
  endtask

  task automatic check_pixels(input string nm);
    int bad;
    bad = 0;
    checks++;
    if (q_d.size() != 100) begin
      errors++;
      $display("FAIL %s_count: got %0d pixels, expected 100", nm, q_d.size());
    end
    for (int i = 0; i < q_d.size(); i++)
      if (q_x[i] != i % 10 || q_y[i] != i / 10 || q_d[i] != i) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_coords: %0d pixels wrong, expected 0", nm, bad);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    checks++;
    if ({pix_valid, frame_done, frame_ok, err_early_eol, err_late_eol, err_early_sof, err_no_sof} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 0000000",
               {pix_valid, frame_done, frame_ok, err_early_eol, err_late_eol, err_early_sof, err_no_sof});
    end
    checks++;
    if (frame_checksum !== 32'd0 || frames_good !== 16'd0 || frames_bad !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: cks=%0d good=%0d bad=%0d, expected 0/0/0",
               frame_checksum, frames_good, frames_bad);
    end
    checks++;
    if (tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: got %b, expected 1", tready);
    end
    @(negedge sys_clk);
    clear_mon();
  endtask

  task automatic test_frame_nostall();
    int b;
    b = ndone;
    send_frame();
    settle();
    check_pixels("nostall");
    checks++;
    if (ndone - b != 1 || last_ok !== 1'b1) begin
      errors++;
      $display("FAIL nostall_done: dones=%0d ok=%b, expected 1/1", ndone - b, last_ok);
    end
    checks++;
    if (q_c.size() == 0 || done_cyc - q_c[0] != 99) begin
      errors++;
      $display("FAIL nostall_latency: done %0d cycles after SOF pixel, expected 99", done_cyc - (q_c.size() ? q_c[0] : 0));
    end
    checks++;
    if (frame_checksum !== 32'd4950 || frames_good !== 16'd1 || frames_bad !== 16'd0) begin
      errors++;
      $display("FAIL nostall_stats: cks=%0d good=%0d bad=%0d, expected 4950/1/0",
               frame_checksum, frames_good, frames_bad);
    end
  endtask

  task automatic test_frame_stall();
    clear_mon();
    stall_en = 1'b1;
    #1;
    send_frame();
    settle();
    stall_en = 1'b0;
    check_pixels("stall");
    checks++;
    if (q_c.size() == 0 || done_cyc - q_c[0] <= 99) begin
      errors++;
      $display("FAIL stall_backpressure: frame took %0d cycles, expected > 99", done_cyc - (q_c.size() ? q_c[0] : 0));
    end
    checks++;
    if (frame_checksum !== 32'd4950 || frames_good !== 16'd2 || last_ok !== 1'b1) begin
      errors++;
      $display("FAIL stall_stats: cks=%0d good=%0d ok=%b, expected 4950/2/1",
               frame_checksum, frames_good, last_ok);
    end
  endtask

  task automatic test_early_eol();
    int b;
    do_reset();
    b = ndone;
    send(8'd0, 1'b1, 1'b0);
    send(8'd1, 1'b0, 1'b0);
    send(8'd2, 1'b0, 1'b1);
    for (int i = 10; i < 100; i++) send(8'(i), 1'b0, (i % 10) == 9);
    settle();
    checks++;
    if (q_d.size() != 93 || q_x[3] != 0 || q_y[3] != 1) begin
      errors++;
      $display("FAIL early_eol_next: n=%0d, 4th pixel (%0d,%0d), expected 93 and (0,1)",
               q_d.size(), q_x[3], q_y[3]);
    end
    checks++;
    if (err_early_eol !== 1'b1 || err_late_eol !== 1'b0) begin
      errors++;
      $display("FAIL early_eol_flags: early=%b late=%b, expected 1/0", err_early_eol, err_late_eol);
    end
    checks++;
    if (ndone - b != 1 || last_ok !== 1'b0 || frames_bad !== 16'd1 || frames_good !== 16'd0 || frame_checksum !== 32'd4908) begin
      errors++;
      $display("FAIL early_eol_frame: dones=%0d ok=%b bad=%0d good=%0d cks=%0d, expected 1/0/1/0/4908",
               ndone - b, last_ok, frames_bad, frames_good, frame_checksum);
    end
  endtask

  task automatic test_late_eol();
    do_reset();
    for (int i = 0; i < 10; i++) send(8'(i), i == 0, 1'b0);
    send(8'd200, 1'b0, 1'b0);
    send(8'd201, 1'b0, 1'b1);
    for (int i = 10; i < 100; i++) send(8'(i), 1'b0, (i % 10) == 9);
    settle();
    check_pixels("late_eol");
    checks++;
    if (err_late_eol !== 1'b1 || err_early_eol !== 1'b0) begin
      errors++;
      $display("FAIL late_eol_flags: late=%b early=%b, expected 1/0", err_late_eol, err_early_eol);
    end
    checks++;
    if (last_ok !== 1'b0 || frames_bad !== 16'd1 || frame_checksum !== 32'd4950) begin
      errors++;
      $display("FAIL late_eol_frame: ok=%b bad=%0d cks=%0d, expected 0/1/4950",
               last_ok, frames_bad, frame_checksum);
    end
  endtask

  task automatic test_no_sof();
    int b;
    do_reset();
    b = ndone;
    for (int i = 0; i < 100; i++) send(8'(i), 1'b0, (i % 10) == 9);
    settle();
    checks++;
    if (q_d.size() != 0 || ndone != b || err_no_sof !== 1'b1) begin
      errors++;
      $display("FAIL no_sof_discard: pixels=%0d dones=%0d flag=%b, expected 0/0/1",
               q_d.size(), ndone - b, err_no_sof);
    end
    send_frame();
    settle();
    check_pixels("no_sof_recover");
    checks++;
    if (last_ok !== 1'b1 || frames_good !== 16'd1 || frames_bad !== 16'd0) begin
      errors++;
      $display("FAIL no_sof_recover_frame: ok=%b good=%0d bad=%0d, expected 1/1/0",
               last_ok, frames_good, frames_bad);
    end
  endtask

  task automatic test_early_sof();
    int b;
    do_reset();
    b = ndone;
    for (int i = 0; i < 35; i++) send(8'(i), i == 0, (i % 10) == 9);
    send(8'd77, 1'b1, 1'b0);
    settle();
    checks++;
    if (err_early_sof !== 1'b1 || frames_bad !== 16'd1 || ndone != b) begin
      errors++;
      $display("FAIL early_sof_abort: flag=%b bad=%0d dones=%0d, expected 1/1/0",
               err_early_sof, frames_bad, ndone - b);
    end
    checks++;
    if (q_d.size() != 36 || q_x[35] != 0 || q_y[35] != 0 || q_d[35] != 77) begin
      errors++;
      $display("FAIL early_sof_pixel: n=%0d last=(%0d,%0d) data=%0d, expected 36 (0,0) 77",
               q_d.size(), q_x[q_x.size()-1], q_y[q_y.size()-1], q_d[q_d.size()-1]);
    end
    for (int i = 1; i < 100; i++) send(8'(i), 1'b0, (i % 10) == 9);
    settle();
    checks++;
    if (ndone - b != 1 || last_ok !== 1'b1 || frames_good !== 16'd1 || frames_bad !== 16'd1 || frame_checksum !== 32'd5027) begin
      errors++;
      $display("FAIL early_sof_frame: dones=%0d ok=%b good=%0d bad=%0d cks=%0d, expected 1/1/1/1/5027",
               ndone - b, last_ok, frames_good, frames_bad, frame_checksum);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 15; i++) send(8'(i), i == 0, (i % 10) == 9);
    do_reset();
    send_frame();
    settle();
    check_pixels("midreset");
    checks++;
    if (last_ok !== 1'b1 || frames_good !== 16'd1 || frames_bad !== 16'd0 || err_early_sof !== 1'b0) begin
      errors++;
      $display("FAIL midreset_frame: ok=%b good=%0d bad=%0d esof=%b, expected 1/1/0/0",
               last_ok, frames_good, frames_bad, err_early_sof);
    end
  endtask

  initial begin
    test_reset();
    test_frame_nostall();
    test_frame_stall();
    test_early_eol();
    test_late_eol();
    test_no_sof();
    test_early_sof();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
